// File: rtl/cache_pkg.sv
// Shared refill/cache definitions: state encoding and line geometry.
package cache_pkg;

    localparam int LINE_WORDS       = 4;
    localparam int OFFSET_BITS      = 4;
    localparam int WORD_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } refill_state_t;

endpackage

// File: rtl/cache_refill_line_buffer.sv
// Line buffer: four word registers filled one beat at a time, cleared by reset.
module refill_line_buffer
    import cache_pkg::*;
#(
    parameter int DATA = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en_i,
    input  logic [WORD_OFFSET_BITS-1:0] idx_i,
    input  logic [DATA-1:0]             wdata_i,
    output logic [DATA-1:0]             word0_o,
    output logic [DATA-1:0]             word1_o,
    output logic [DATA-1:0]             word2_o,
    output logic [DATA-1:0]             word3_o
);

    logic [DATA-1:0] words_q [LINE_WORDS];
    logic [DATA-1:0] words_d [LINE_WORDS];

    // Overwrite only the indexed word on a completed beat; others hold.
    always_comb begin
        words_d = words_q;
        if (wr_en_i) begin
            words_d[idx_i] = wdata_i;
        end
    end

    // Word storage; reset wipes any partially collected line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '{default: '0};
        end else begin
            words_q <= words_d;
        end
    end

    assign word0_o = words_q[0];
    assign word1_o = words_q[1];
    assign word2_o = words_q[2];
    assign word3_o = words_q[3];

endmodule

// File: rtl/cache_refill.sv
// Miss handler: fetches a 4-word line in ascending beats, then presents it for one cycle.
module cache_refill
    import cache_pkg::*;
#(
    parameter int DATA       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            miss_i,
    input  logic [DATA-1:0] addr_i,
    output logic            mem_req_o,
    output logic [DATA-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [DATA-1:0] mem_rdata_i,
    output logic [DATA-1:0] dataWord0_o,
    output logic [DATA-1:0] dataWord1_o,
    output logic [DATA-1:0] dataWord2_o,
    output logic [DATA-1:0] dataWord3_o,
    output logic [DATA-1:0] fill_addr_o,
    output logic            fill_valid_o,
    output logic            stall_o
);

    localparam logic [WORD_OFFSET_BITS-1:0] LAST_BEAT = WORD_OFFSET_BITS'(LINE_WORDS - 1);

    refill_state_t               state_q, state_d;
    logic [WORD_OFFSET_BITS-1:0] beat_q, beat_d;
    logic [DATA-1:0]             base_q, base_d;
    logic                        wr_en;

    // Byte-offset bits of the miss address only select within the line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[OFFSET_BITS-1:0];

    // Next-state, beat sequencing and handshake-facing outputs.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        wr_en        = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = base_q;
        fill_valid_o = 1'b0;
        stall_o      = 1'b1;
        case (state_q)
            IDLE: begin
                stall_o = miss_i & ~rst;
                if (miss_i) begin
                    base_d  = {addr_i[DATA-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    beat_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {base_q[DATA-1:OFFSET_BITS], beat_q, 2'b00};
                if (mem_ack_i) begin
                    wr_en = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = FILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FILL: begin
                fill_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, beat counter and line base registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    assign fill_addr_o = base_q;

    refill_line_buffer #(
        .DATA(DATA)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (wr_en),
        .idx_i   (beat_q),
        .wdata_i (mem_rdata_i),
        .word0_o (dataWord0_o),
        .word1_o (dataWord1_o),
        .word2_o (dataWord2_o),
        .word3_o (dataWord3_o)
    );

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: each task drives one scenario and checks inline.
module tb_cache_refill;

    logic        clk;
    logic        rst;
    logic        miss_i;
    logic [31:0] addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] dataWord0_o;
    logic [31:0] dataWord1_o;
    logic [31:0] dataWord2_o;
    logic [31:0] dataWord3_o;
    logic [31:0] fill_addr_o;
    logic        fill_valid_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    cache_refill #(
        .DATA(32),
        .LINE_WORDS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_i       (miss_i),
        .addr_i       (addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .dataWord0_o  (dataWord0_o),
        .dataWord1_o  (dataWord1_o),
        .dataWord2_o  (dataWord2_o),
        .dataWord3_o  (dataWord3_o),
        .fill_addr_o  (fill_addr_o),
        .fill_valid_o (fill_valid_o),
        .stall_o      (stall_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_i = 1'b0; addr_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        tick(); tick();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %0b exp 0", mem_req_o); end
        checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_fill_valid got %0b exp 0", fill_valid_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got %0b exp 0", stall_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_addr got %h exp 0", mem_addr_o); end
        checks++; if (fill_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_fill_addr got %h exp 0", fill_addr_o); end
        checks++;
        if ({dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL rst_words got %h %h %h %h exp all 0", dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        int stall_cnt;
        stall_cnt = 0;
        miss_i = 1'b1; addr_i = 32'h0000_1234; mem_ack_i = 1'b1;
        #1;
        if (stall_o === 1'b1) stall_cnt++;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_miss_req got %0b exp 0", mem_req_o); end
        tick();
        miss_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rdata_i = 32'hB0 + k;
            #1;
            if (stall_o === 1'b1) stall_cnt++;
            checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL zw_req beat%0d got %0b exp 1", k, mem_req_o); end
            checks++; if (mem_addr_o !== 32'h1230 + 4 * k) begin errors++; $display("[TB] FAIL zw_addr beat%0d got %h exp %h", k, mem_addr_o, 32'h1230 + 4 * k); end
            checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_early_fill beat%0d got %0b exp 0", k, fill_valid_o); end
            tick();
        end
        if (stall_o === 1'b1) stall_cnt++;
        checks++; if (fill_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL zw_fill_valid got %0b exp 1", fill_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_fill_req got %0b exp 0", mem_req_o); end
        checks++; if (fill_addr_o !== 32'h1230) begin errors++; $display("[TB] FAIL zw_fill_addr got %h exp 1230", fill_addr_o); end
        checks++;
        if ({dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o} !== {32'hB0, 32'hB1, 32'hB2, 32'hB3}) begin
            errors++;
            $display("[TB] FAIL zw_words got %h %h %h %h exp b0 b1 b2 b3", dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o);
        end
        tick();
        if (stall_o === 1'b1) stall_cnt++;
        checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL zw_fill_one_cycle got %0b exp 0", fill_valid_o); end
        checks++; if (mem_addr_o !== 32'h1230) begin errors++; $display("[TB] FAIL zw_idle_addr got %h exp 1230", mem_addr_o); end
        checks++; if (stall_cnt != 6) begin errors++; $display("[TB] FAIL zw_stall_cycles got %0d exp 6", stall_cnt); end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_ack_idle();
        miss_i = 1'b0; mem_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_rdata_i = 32'h5555_0000 + k;
            #1;
            checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL ai_stall cyc%0d got %0b exp 0", k, stall_o); end
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL ai_req cyc%0d got %0b exp 0", k, mem_req_o); end
            tick();
        end
        checks++; if (dataWord0_o !== 32'hB0) begin errors++; $display("[TB] FAIL ai_word0 got %h exp b0", dataWord0_o); end
        checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ai_fill_valid got %0b exp 0", fill_valid_o); end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_wait_states();
        miss_i = 1'b1; addr_i = 32'h0000_1234; mem_ack_i = 1'b0;
        tick();
        miss_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                mem_ack_i   = (w == 2);
                mem_rdata_i = (w == 2) ? 32'hA0 + k : 32'hDEAD_BEEF;
                #1;
                checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL ws_req beat%0d w%0d got %0b exp 1", k, w, mem_req_o); end
                checks++; if (mem_addr_o !== 32'h1230 + 4 * k) begin errors++; $display("[TB] FAIL ws_addr beat%0d w%0d got %h exp %h", k, w, mem_addr_o, 32'h1230 + 4 * k); end
                tick();
            end
        end
        mem_ack_i = 1'b0;
        #1;
        checks++; if (fill_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ws_fill_valid got %0b exp 1", fill_valid_o); end
        checks++;
        if ({dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
            errors++;
            $display("[TB] FAIL ws_words got %h %h %h %h exp a0 a1 a2 a3", dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o);
        end
        tick();
    endtask

    task automatic test_ignore_inputs();
        miss_i = 1'b1; addr_i = 32'h0000_5678; mem_ack_i = 1'b1;
        tick();
        addr_i = 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
            miss_i      = k[0];
            mem_rdata_i = 32'hC0 + k;
            #1;
            checks++; if (mem_addr_o !== 32'h5670 + 4 * k) begin errors++; $display("[TB] FAIL ig_addr beat%0d got %h exp %h", k, mem_addr_o, 32'h5670 + 4 * k); end
            tick();
        end
        miss_i = 1'b0; mem_ack_i = 1'b0;
        #1;
        checks++; if (fill_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ig_fill_valid got %0b exp 1", fill_valid_o); end
        checks++; if (fill_addr_o !== 32'h5670) begin errors++; $display("[TB] FAIL ig_fill_addr got %h exp 5670", fill_addr_o); end
        checks++; if (dataWord2_o !== 32'hC2) begin errors++; $display("[TB] FAIL ig_word2 got %h exp c2", dataWord2_o); end
        tick();
        checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL ig_idle_stall got %0b exp 0", stall_o); end
    endtask

    task automatic test_back_to_back();
        miss_i = 1'b1; addr_i = 32'h0000_1234; mem_ack_i = 1'b1; mem_rdata_i = 32'h11;
        tick();
        addr_i = 32'h0000_8800;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (fill_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bb_fill1 got %0b exp 1", fill_valid_o); end
        checks++; if (fill_addr_o !== 32'h1230) begin errors++; $display("[TB] FAIL bb_fill1_addr got %h exp 1230", fill_addr_o); end
        tick();
        checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL bb_idle_stall got %0b exp 1", stall_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL bb_idle_req got %0b exp 0", mem_req_o); end
        tick();
        miss_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL bb_req2 got %0b exp 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h8800) begin errors++; $display("[TB] FAIL bb_addr2 got %h exp 8800", mem_addr_o); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (fill_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bb_fill2 got %0b exp 1", fill_valid_o); end
        checks++; if (fill_addr_o !== 32'h8800) begin errors++; $display("[TB] FAIL bb_fill2_addr got %h exp 8800", fill_addr_o); end
        mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        miss_i = 1'b1; addr_i = 32'h0000_1234; mem_ack_i = 1'b1;
        tick();
        miss_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rdata_i = 32'hE0 + k;
            tick();
        end
        mem_ack_i = 1'b0;
        #1;
        checks++; if (dataWord2_o !== 32'hE2) begin errors++; $display("[TB] FAIL ra_word2_pre got %h exp e2", dataWord2_o); end
        checks++; if (mem_addr_o !== 32'h123C) begin errors++; $display("[TB] FAIL ra_addr_pre got %h exp 123c", mem_addr_o); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL ra_req got %0b exp 0", mem_req_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL ra_stall got %0b exp 0", stall_o); end
        checks++;
        if ({dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL ra_words got %h %h %h %h exp all 0", dataWord0_o, dataWord1_o, dataWord2_o, dataWord3_o);
        end
        tick();
        checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ra_fill_valid got %0b exp 0", fill_valid_o); end
        rst = 1'b0;
        tick();
        checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ra_fill_after got %0b exp 0", fill_valid_o); end
        miss_i = 1'b1; addr_i = 32'h0000_1234;
        tick();
        miss_i = 1'b0;
        #1;
        checks++; if (mem_addr_o !== 32'h1230) begin errors++; $display("[TB] FAIL ra_restart_addr got %h exp 1230", mem_addr_o); end
        mem_ack_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        mem_ack_i = 1'b0;
        checks++; if (fill_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ra_restart_fill got %0b exp 1", fill_valid_o); end
        tick();
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] cache_refill directed run");
        test_reset();
        test_zero_wait();
        test_ack_idle();
        test_wait_states();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill.md
# cache_refill

Miss handler and line-fill engine that sits directly upstream of the L1 data cache. When the cache reports a miss, it fetches the 4-word (16-byte) line containing the missing address from data memory, one word per memory handshake. It collects the words in a line buffer, then presents the whole line to the cache for one cycle. It also stalls the pipeline for the whole refill.

## Interface
Parameters:
- DATA, 32, data and address width in bits.
- LINE_WORDS, 4, words per cache line; fixed at 4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- miss_i  input  1  cache miss for addr_i, level signal.
- addr_i  input  DATA  byte address of the missing access.
- mem_req_o  output  1  memory read request.
- mem_addr_o  output  DATA  word-aligned address of the current beat.
- mem_ack_i  input  1  memory accepts the beat and returns data in this cycle.
- mem_rdata_i  input  DATA  read data, valid when mem_ack_i is high.
- dataWord0_o..dataWord3_o  output  DATA each  line words at offsets 0x0, 0x4, 0x8 and 0xC.
- fill_addr_o  output  DATA  line base address: tag in [DATA-1:5], set in [4], bits [3:0] zero.
- fill_valid_o  output  1  line is complete; the cache must write it this cycle.
- stall_o  output  1  pipeline hold.

## Operation
- FSM states: IDLE, FETCH, FILL.
- IDLE
  - If miss_i is high at a rising edge:
    - latch base = {addr_i[DATA-1:4], 4'b0};
    - set beat = 0;
    - go to FETCH.
  - Otherwise stay in IDLE.
- FETCH
  - mem_req_o = 1.
  - mem_addr_o = {base[DATA-1:4], beat, 2'b00}.
  - Rising edge with mem_ack_i high:
    - capture mem_rdata_i into word[beat];
    - if beat == 3, go to FILL; otherwise beat increments.
  - Rising edge with mem_ack_i low: no state change. mem_req_o and mem_addr_o stay stable.
- FILL
  - fill_valid_o = 1 for exactly one cycle; mem_req_o = 0.
  - Next state is IDLE.
- stall_o = (state != IDLE) | (state == IDLE & miss_i). This is combinational, so the miss cycle itself is held.
- miss_i and addr_i are ignored outside IDLE; addr_i may change freely after capture.
- If miss_i is still high in the first IDLE cycle after FILL, a new refill starts. The cache must drop miss_i once it has written the line.
- Outside FETCH, mem_addr_o holds {base[DATA-1:4], 4'b0}.
- Beats are issued in ascending order (offset 0, 4, 8, C), never critical-word-first.
- beat is 2 bits; the increment from 3 never occurs because FETCH exits to FILL first.

## Timing
- Reset values (asynchronous, effective immediately):
  - state = IDLE, beat = 0, base = 0, all dataWordN_o = 0;
  - mem_req_o, fill_valid_o and stall_o = 0.
- Reset during FETCH or FILL aborts the refill:
  - mem_req_o drops in the same cycle;
  - no fill_valid_o is produced;
  - the partially captured words are cleared.
- Handshake:
  - a beat completes on the rising edge where mem_req_o and mem_ack_i are both high;
  - a zero-wait memory may hold ack high continuously, giving one beat per cycle;
  - an ack with mem_req_o low is ignored.
- Minimum latency (ack tied high), from the edge that samples miss_i to fill_valid_o:
  - 4 FETCH cycles + 1 FILL cycle, with fill_valid_o high in cycle 5;
  - stall_o is high for 6 cycles including the miss cycle.
- With W wait cycles per beat, the FILL cycle arrives 4·(W+1) cycles after entering FETCH.
- dataWordN_o and fill_addr_o are registered. They are stable throughout FILL and hold their values until the next refill captures over them.

## Structure
- Shared package cache_pkg holds:
  - the refill_state_t enum (IDLE, FETCH, FILL);
  - LINE_WORDS = 4, OFFSET_BITS = 4, WORD_OFFSET_BITS = 2.
- The cache reuses the same package for tag/set slicing.
- One natural sub-module: refill_line_buffer.
  - Contents: 4 × DATA registers.
  - Inputs: write enable, 2-bit index, asynchronous clear.
  - Drives dataWord0_o..dataWord3_o.
- The FSM, beat counter and address generation stay in cache_refill.

## Test plan
- Reset, then pulse miss_i with addr_i = 0x0000_1234 and mem_ack_i tied high:
  - mem_addr_o = 0x1230, 0x1234, 0x1238, 0x123C in consecutive cycles;
  - fill_addr_o = 0x1230;
  - fill_valid_o high for one cycle;
  - stall_o high for 6 cycles.
- Same miss with 2 wait cycles per beat:
  - each mem_addr_o is held 3 cycles;
  - the words captured match rdata 0xA0, 0xA1, 0xA2, 0xA3 at dataWord0_o..dataWord3_o.
- addr_i changes to 0xFFFF_FFF0 and miss_i toggles during FETCH:
  - no effect;
  - the line for the original address completes.
- miss_i held high across FILL:
  - a second refill for the current addr_i starts in the cycle after FILL.
- Assert rst after beat 2 is captured:
  - mem_req_o drops immediately;
  - all dataWordN_o = 0;
  - no fill_valid_o;
  - the next miss restarts from beat 0.
- mem_ack_i high while in IDLE:
  - no capture, no state change, stall_o low.
